airlock_chamber_ctrl: RTL and testbench
=======================================

Name: airlock_chamber_ctrl

Overview:
- Downstream consumer of the pressure-limit toggle stage.
- Takes the level `limit` output (0 = WITHIN side, 1 = BEYOND side) as the requested chamber side.
- Sequences a timed pump cycle between the two sides and grants door openings.
- Interlock: never both doors open; no door open while pumping.

Parameters:
- PUMP_CYCLES, default 8: number of clock cycles one full pump-down or pump-up takes; legal range 2..2^CW.
- CW, default 4: width of the pump countdown counter; must hold PUMP_CYCLES-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- limit  input  1  requested side from the upstream limit stage; 0 = inner/WITHIN, 1 = outer/BEYOND; level, held.
- door_req  input  1  level request to open the door on the side the chamber currently sits at.
- inner_door  output  1  1 = inner door open command.
- outer_door  output  1  1 = outer door open command.
- pumping  output  1  1 = pump active (either direction).
- at_outer  output  1  1 = chamber sealed or open at the outer side.
- count  output  CW  remaining pump cycles minus one; 0 when not pumping.

Behaviour:
- States (3-bit register): INNER_SEALED, INNER_OPEN, PUMP_DOWN, OUTER_SEALED, OUTER_OPEN, PUMP_UP.
- Moore outputs, decoded from the state register only:
  - inner_door = (INNER_OPEN); outer_door = (OUTER_OPEN).
  - pumping = (PUMP_DOWN or PUMP_UP).
  - at_outer = (OUTER_SEALED or OUTER_OPEN).
  - count is a register driven directly.
- reset low: immediately (no clock) state = INNER_SEALED, count = 0, all outputs 0. Applies mid-pump and with a door open.
- reset release: first active edge is the first edge with reset high.
- INNER_SEALED:
  - limit=1 -> PUMP_DOWN, count <= PUMP_CYCLES-1.
  - else door_req=1 -> INNER_OPEN.
  - limit has priority over door_req.
- INNER_OPEN:
  - door_req=0 -> INNER_SEALED.
  - limit ignored while open; the door must close first. Because limit is a held level, the pump starts one cycle after sealing.
- PUMP_DOWN (door_req ignored):
  - limit=0 -> PUMP_UP, count <= PUMP_CYCLES-1-count (reversal).
  - else count==0 -> OUTER_SEALED.
  - else count <= count-1.
- OUTER_SEALED:
  - limit=0 -> PUMP_UP, count <= PUMP_CYCLES-1.
  - else door_req=1 -> OUTER_OPEN.
- OUTER_OPEN: door_req=0 -> OUTER_SEALED; limit ignored.
- PUMP_UP: mirror of PUMP_DOWN.
  - limit=1 -> PUMP_DOWN with reversed count.
  - count==0 -> INNER_SEALED.
- count <= 0 on every transition into a sealed state.
- Latency:
  - limit change sampled at edge k -> pumping=1 after edge k.
  - pumping stays 1 for exactly PUMP_CYCLES cycles.
  - door_req sampled at edge j in a sealed state -> door=1 after edge j.
  - door_req drop -> door=0 after the next edge.
- Arithmetic: count is unsigned CW bits; decrement never below 0; no wrap.
- Reversal is allowed any number of times; reversal takes priority over count==0 termination.
- Invariants, every cycle:
  - inner_door & outer_door == 0.
  - (inner_door|outer_door) & pumping == 0.
  - State encodings outside the six legal values recover to INNER_SEALED on the next edge.

Test Plan:
- Hold reset low 2 cycles, then limit=0, door_req=0 -> all outputs 0, count=0. Reassert reset mid-PUMP_DOWN at count=3 -> outputs 0 with no clock edge.
- PUMP_CYCLES=8, limit 0->1 at edge 0 -> pumping=1 after edges 0..7, count 7,6,...,0. After edge 8: pumping=0, at_outer=1, count=0.
- In OUTER_SEALED, door_req=1 for 3 cycles then 0 -> outer_door=1 for exactly 3 cycles; inner_door stays 0 throughout.
- In INNER_OPEN, raise limit=1 with door_req=1 for 4 cycles, then door_req=0 -> inner_door held 4 cycles, then INNER_SEALED for 1 cycle, then PUMP_DOWN with count=7.
- limit 0->1, then back to 0 when count=4 -> next state PUMP_UP, count=3. pumping for 4 more cycles, then INNER_SEALED with at_outer=0.
- In INNER_SEALED, drive limit=1 and door_req=1 on the same edge -> PUMP_DOWN; inner_door never asserts.

Source files
------------

// File: rtl/airlock_chamber_ctrl.sv
// Airlock chamber sequencer: follows the requested side from the limit stage,
// runs a timed pump cycle between sides and grants interlocked door openings.
module airlock_chamber_ctrl #(
   parameter int PUMP_CYCLES = 8,
   parameter int CW          = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          limit,
   input  logic          door_req,
   output logic          inner_door,
   output logic          outer_door,
   output logic          pumping,
   output logic          at_outer,
   output logic [CW-1:0] count
);

   typedef enum logic [2:0] {
      INNER_SEALED = 3'd0,
      INNER_OPEN   = 3'd1,
      PUMP_DOWN    = 3'd2,
      OUTER_SEALED = 3'd3,
      OUTER_OPEN   = 3'd4,
      PUMP_UP      = 3'd5
   } state_e;

   localparam logic [CW-1:0] TOP = CW'(PUMP_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         INNER_SEALED: begin
            if (limit) begin
               state_d = PUMP_DOWN;
               count_d = TOP;
            end else if (door_req) begin
               state_d = INNER_OPEN;
            end
         end
         INNER_OPEN: begin
            if (!door_req) state_d = INNER_SEALED;
         end
         PUMP_DOWN: begin
            // Reversal resumes from the equivalent point of the opposite stroke.
            if (!limit) begin
               state_d = PUMP_UP;
               count_d = TOP - count_q;
            end else if (count_q == '0) begin
               state_d = OUTER_SEALED;
               count_d = '0;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         OUTER_SEALED: begin
            if (!limit) begin
               state_d = PUMP_UP;
               count_d = TOP;
            end else if (door_req) begin
               state_d = OUTER_OPEN;
            end
         end
         OUTER_OPEN: begin
            if (!door_req) state_d = OUTER_SEALED;
         end
         PUMP_UP: begin
            if (limit) begin
               state_d = PUMP_DOWN;
               count_d = TOP - count_q;
            end else if (count_q == '0) begin
               state_d = INNER_SEALED;
               count_d = '0;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         default: begin
            state_d = INNER_SEALED;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= INNER_SEALED;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign inner_door = (state_q == INNER_OPEN);
   assign outer_door = (state_q == OUTER_OPEN);
   assign pumping    = (state_q == PUMP_DOWN) || (state_q == PUMP_UP);
   assign at_outer   = (state_q == OUTER_SEALED) || (state_q == OUTER_OPEN);
   assign count      = count_q;

endmodule

// File: tb/tb_airlock_chamber_ctrl.sv
// Scoreboard bench for airlock_chamber_ctrl: a side/door/remaining-time model
// predicts each cycle, a monitor compares after every rising edge.
module tb_airlock_chamber_ctrl;
   localparam int N  = 8;
   localparam int CW = 4;

   typedef struct packed {
      logic          inner_door;
      logic          outer_door;
      logic          pumping;
      logic          at_outer;
      logic [CW-1:0] count;
   } obs_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          limit = 1'b0;
   logic          door_req = 1'b0;
   logic          inner_door, outer_door, pumping, at_outer;
   logic [CW-1:0] count;

   int checks = 0;
   int failures = 0;

   obs_t exp_q[$];

   // Model: chamber side, door open flag, cycles of pumping still to run, pump target side.
   int m_side = 0;
   int m_open = 0;
   int m_rem  = 0;
   int m_tgt  = 0;

   airlock_chamber_ctrl #(.PUMP_CYCLES(N), .CW(CW)) dut (
      .clk(clk), .reset(reset), .limit(limit), .door_req(door_req),
      .inner_door(inner_door), .outer_door(outer_door), .pumping(pumping),
      .at_outer(at_outer), .count(count)
   );

   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o.inner_door = inner_door;
      o.outer_door = outer_door;
      o.pumping    = pumping;
      o.at_outer   = at_outer;
      o.count      = count;
      return o;
   endfunction

   function automatic obs_t predict();
      obs_t o;
      o.inner_door = (m_open == 1) && (m_side == 0);
      o.outer_door = (m_open == 1) && (m_side == 1);
      o.pumping    = (m_rem > 0);
      o.at_outer   = (m_rem == 0) && (m_side == 1);
      o.count      = (m_rem > 0) ? CW'(m_rem - 1) : '0;
      return o;
   endfunction

   task automatic check(input string name, input obs_t got, input obs_t want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%b_%b_%b_%b_%0d want=%b_%b_%b_%b_%0d", name,
                  got.inner_door, got.outer_door, got.pumping, got.at_outer, got.count,
                  want.inner_door, want.outer_door, want.pumping, want.at_outer, want.count);
      end
   endtask

   // Drive inputs for the next edge and push the expected post-edge response.
   task automatic step(input logic l, input logic d);
      @(negedge clk);
      limit    = l;
      door_req = d;
      if (m_rem > 0) begin
         if (int'(l) != m_tgt) begin
            m_rem = N - m_rem + 1;
            m_tgt = int'(l);
         end else if (m_rem == 1) begin
            m_rem  = 0;
            m_side = m_tgt;
         end else begin
            m_rem--;
         end
      end else if (m_open == 1) begin
         if (!d) m_open = 0;
      end else if (int'(l) != m_side) begin
         m_rem = N;
         m_tgt = int'(l);
      end else if (d) begin
         m_open = 1;
      end
      exp_q.push_back(predict());
   endtask

   task automatic do_reset(input string name);
      obs_t z;
      z = '0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check(name, sample(), z);
      m_side = 0; m_open = 0; m_rem = 0; m_tgt = 0;
      limit = 1'b0; door_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check({name, "_held"}, sample(), z);
      reset = 1'b1;
   endtask

   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         obs_t want;
         want = exp_q.pop_front();
         check("cycle", sample(), want);
         checks++;
         if ((inner_door & outer_door) || ((inner_door | outer_door) & pumping)) begin
            failures++;
            $display("FAIL interlock got=%b%b%b want=no_overlap", inner_door, outer_door, pumping);
         end
      end
   end

   initial begin
      // Power-up reset held two cycles.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_init", sample(), obs_t'(0));
      reset = 1'b1;
      step(0, 0); step(0, 0);
      // Full pump-down, then outer door for 3 cycles.
      repeat (N) step(1, 0);
      step(1, 0);
      repeat (3) step(1, 1);
      step(1, 0); step(1, 0);
      // Pump back up to inner.
      repeat (N + 1) step(0, 0);
      // Inner door open, limit raised while open: must seal before pumping.
      step(0, 1);
      repeat (4) step(1, 1);
      step(1, 0);
      repeat (N + 1) step(1, 0);
      repeat (N + 1) step(0, 0);
      // Reversal at count 4.
      repeat (4) step(1, 0);
      repeat (N) step(0, 0);
      step(0, 0);
      // limit and door_req together in INNER_SEALED: pump wins.
      step(1, 1); step(1, 1); step(1, 0);
      repeat (N) step(0, 0);
      step(0, 0);
      // Reset mid pump-down at count 3.
      repeat (5) step(1, 0);
      @(posedge clk); #2;
      if (m_rem != 4) begin
         checks++; failures++;
         $display("FAIL pre_reset_count got=%0d want=4", m_rem - 1);
      end
      do_reset("reset_mid_pump");
      // Reset with a door open.
      step(0, 1); step(0, 1);
      @(posedge clk); #2;
      do_reset("reset_door_open");
      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic l, d;
         l = ($urandom_range(0, 9) == 0) ? ~limit : limit;
         d = ($urandom_range(0, 3) == 0) ? ~door_req : door_req;
         step(l, d);
      end
      @(posedge clk); #2;
      if (exp_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL queue_drain got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
